// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel, decode handoff
// and control-unit redirect. The fetch unit is the master, memory/decode/control the slave.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  ImemReqValid_o;
  logic                  ImemReqReady_i;
  logic [ADDR_WIDTH-1:0] ImemAddr_o;
  logic                  ImemRspValid_i;
  logic [DATA_WIDTH-1:0] ImemRspData_i;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic [ADDR_WIDTH-1:0] PC_o;
  logic                  InstrValid_o;
  logic                  InstrReady_i;
  logic                  Redirect_i;
  logic [ADDR_WIDTH-1:0] RedirectPC_i;
  logic                  Misalign_o;

  modport master (
    output ImemReqValid_o, ImemAddr_o, Instr_o, PC_o, InstrValid_o, Misalign_o,
    input  ImemReqReady_i, ImemRspValid_i, ImemRspData_i, InstrReady_i,
    input  Redirect_i, RedirectPC_i
  );

  modport slave (
    input  ImemReqValid_o, ImemAddr_o, Instr_o, PC_o, InstrValid_o, Misalign_o,
    output ImemReqReady_i, ImemRspValid_i, ImemRspData_i, InstrReady_i,
    output Redirect_i, RedirectPC_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, in-order memory requests, small
// PC/word queue towards decode, redirect with stale-response discard.
// Optional macro FETCH_ALIGN_CHECK_EN: word-align redirect targets and pulse Misalign_o.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [PTR_W-1:0]      head_ptr_reg;
  logic [PTR_W-1:0]      tail_ptr_reg;
  logic [PTR_W-1:0]      fill_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      outstanding_reg;
  logic [CNT_W-1:0]      discard_reg;

  logic [ADDR_WIDTH-1:0] pc_q     [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0]      filled_q;

  logic [CNT_W-1:0]      alloc;
  logic [CNT_W-1:0]      outstanding_after;
  logic [CNT_W-1:0]      discard_next;
  logic                  req_valid;
  logic                  accept;
  logic                  rsp_ok;
  logic                  rsp_fill;
  logic                  rsp_drop;
  logic                  instr_valid;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  // Discarded in-flight words still hold a slot in the budget until they return,
  // so alloc counts queue entries plus pending discards.
  assign alloc             = count_reg + discard_reg;
  assign req_valid         = (state_reg != BOOT) && !bus.Redirect_i && (alloc < CNT_W'(DEPTH));
  assign accept            = req_valid && bus.ImemReqReady_i;
  assign rsp_ok            = bus.ImemRspValid_i && (outstanding_reg != '0);
  assign rsp_drop          = rsp_ok && (discard_reg != '0);
  assign rsp_fill          = rsp_ok && (discard_reg == '0);
  assign instr_valid       = filled_q[head_ptr_reg];
  assign pop               = instr_valid && bus.InstrReady_i;
  assign outstanding_after = outstanding_reg - CNT_W'(rsp_ok);
  assign discard_next      = discard_reg - CNT_W'(rsp_drop);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_reg;
  assign redirect_pc    = {bus.RedirectPC_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus.Misalign_o = misalign_reg;
`else
  assign redirect_pc    = bus.RedirectPC_i;
  assign bus.Misalign_o = 1'b0;
`endif

  assign bus.ImemReqValid_o = req_valid;
  assign bus.ImemAddr_o     = fetch_pc_reg;
  assign bus.InstrValid_o   = instr_valid;
  assign bus.Instr_o        = data_q[head_ptr_reg];
  assign bus.PC_o           = pc_q[head_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      head_ptr_reg    <= '0;
      tail_ptr_reg    <= '0;
      fill_ptr_reg    <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_reg    <= 1'b0;
`endif
    end else begin
      outstanding_reg <= outstanding_reg + CNT_W'(accept) - CNT_W'(rsp_ok);
      if (bus.Redirect_i) begin
        // Everything queued is flushed; whatever is still in flight after this
        // cycle's response must be thrown away when it returns.
        fetch_pc_reg <= redirect_pc;
        head_ptr_reg <= '0;
        tail_ptr_reg <= '0;
        fill_ptr_reg <= '0;
        count_reg    <= '0;
        discard_reg  <= outstanding_after;
        state_reg    <= (outstanding_after != '0) ? DRAIN : RUN;
      end else begin
        if (accept) begin
          fetch_pc_reg <= fetch_pc_reg + ADDR_WIDTH'(4);
          tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
        end
        if (rsp_fill) begin
          fill_ptr_reg <= fill_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          head_ptr_reg <= head_ptr_reg + PTR_W'(1);
        end
        count_reg   <= count_reg + CNT_W'(accept) - CNT_W'(pop);
        discard_reg <= discard_next;
        case (state_reg)
          BOOT:    state_reg <= RUN;
          RUN:     state_reg <= RUN;
          DRAIN:   state_reg <= (discard_next == '0) ? RUN : DRAIN;
          default: state_reg <= BOOT;
        endcase
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_reg <= bus.Redirect_i && (bus.RedirectPC_i[1:0] != 2'b00);
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_WIDTH-1:0] pc_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  filled_reg;
      logic                  alloc_hit;
      logic                  fill_hit;
      logic                  pop_hit;

      assign alloc_hit = accept   && (tail_ptr_reg == PTR_W'(gi));
      assign fill_hit  = rsp_fill && (fill_ptr_reg == PTR_W'(gi));
      assign pop_hit   = pop      && (head_ptr_reg == PTR_W'(gi));

      // Entries reset to NOP at RESET_PC so the decode outputs show a benign
      // instruction while nothing has been fetched yet.
      always_ff @(posedge clk) begin
        if (rst) begin
          pc_reg     <= RESET_PC;
          data_reg   <= NOP;
          filled_reg <= 1'b0;
        end else begin
          if (alloc_hit) begin
            pc_reg <= fetch_pc_reg;
          end
          if (fill_hit) begin
            data_reg <= bus.ImemRspData_i;
          end
          if (bus.Redirect_i) begin
            filled_reg <= 1'b0;
          end else if (fill_hit) begin
            filled_reg <= 1'b1;
          end else if (pop_hit) begin
            filled_reg <= 1'b0;
          end
        end
      end

      assign pc_q[gi]     = pc_reg;
      assign data_q[gi]   = data_reg;
      assign filled_q[gi] = filled_reg;
    end
  endgenerate

  // A response with nothing outstanding is ignored by the logic above.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(bus.ImemRspValid_i && (outstanding_reg == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: in-order memory model with optional
// response hold, accept/delivery logs, one task per scenario.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rsp_hold = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  logic [31:0] rsp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] dpc_log[$];
  logic [31:0] din_log[$];

  instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory word at address a is {16'hC0DE, a[15:0]}; responses in order, one per cycle.
  always @(posedge clk) begin
    logic [31:0] a;
    if (rst) begin
      rsp_q.delete();
      bus.ImemRspValid_i <= 1'b0;
      bus.ImemRspData_i  <= 32'h0;
    end else begin
      if (bus.ImemReqValid_o && bus.ImemReqReady_i) rsp_q.push_back(bus.ImemAddr_o);
      if (!rsp_hold && rsp_q.size() > 0) begin
        a = rsp_q.pop_front();
        bus.ImemRspValid_i <= 1'b1;
        bus.ImemRspData_i  <= {16'hC0DE, a[15:0]};
      end else begin
        bus.ImemRspValid_i <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.ImemReqValid_o && bus.ImemReqReady_i) acc_log.push_back(bus.ImemAddr_o);
      if (bus.InstrValid_o && bus.InstrReady_i) begin
        dpc_log.push_back(bus.PC_o);
        din_log.push_back(bus.Instr_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rsp_hold = 1'b0;
    bus.ImemReqReady_i = 1'b1;
    bus.InstrReady_i   = 1'b1;
    bus.Redirect_i     = 1'b0;
    bus.RedirectPC_i   = 32'h0;
    step();
    step();
    acc_log.delete();
    dpc_log.delete();
    din_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0) begin fails++; $display("FAIL rst_reqvalid: got %b want 0", bus.ImemReqValid_o); end
    tests_run++;
    if (bus.ImemAddr_o !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 00000000", bus.ImemAddr_o); end
    tests_run++;
    if (bus.InstrValid_o !== 1'b0) begin fails++; $display("FAIL rst_instrvalid: got %b want 0", bus.InstrValid_o); end
    tests_run++;
    if (bus.Instr_o !== 32'h0000_0013) begin fails++; $display("FAIL rst_instr: got %h want 00000013", bus.Instr_o); end
    tests_run++;
    if (bus.PC_o !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 00000000", bus.PC_o); end
    tests_run++;
    if (bus.Misalign_o !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", bus.Misalign_o); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0) begin fails++; $display("FAIL boot_idle: got %b want 0", bus.ImemReqValid_o); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    step(); // cycle 1
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b1 || bus.ImemAddr_o !== 32'h0) begin
      fails++; $display("FAIL seq_c1_req: got v=%b a=%h want v=1 a=00000000", bus.ImemReqValid_o, bus.ImemAddr_o);
    end
    step(); // cycle 2
    tests_run++;
    if (bus.InstrValid_o !== 1'b0 || bus.ImemAddr_o !== 32'h4) begin
      fails++; $display("FAIL seq_c2: got iv=%b a=%h want iv=0 a=00000004", bus.InstrValid_o, bus.ImemAddr_o);
    end
    step(); // cycle 3
    tests_run++;
    if (bus.InstrValid_o !== 1'b1 || bus.PC_o !== 32'h0 || bus.Instr_o !== 32'hC0DE_0000) begin
      fails++; $display("FAIL seq_first_valid: got iv=%b pc=%h in=%h want iv=1 pc=00000000 in=c0de0000", bus.InstrValid_o, bus.PC_o, bus.Instr_o);
    end
    repeat (5) step();
    tests_run++;
    if (acc_log.size() < 6 || acc_log[5] !== 32'h14) begin
      fails++; $display("FAIL seq_addr5: got n=%0d want acc[5]=00000014", acc_log.size());
    end
    tests_run++;
    if (dpc_log.size() < 4 || dpc_log[3] !== 32'hC || din_log[3] !== 32'hC0DE_000C) begin
      fails++; $display("FAIL seq_deliver3: got n=%0d want pc=0000000c in=c0de000c", dpc_log.size());
    end
    $display("[TB] test_sequential: %0d accepted, %0d delivered", acc_log.size(), dpc_log.size());
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.InstrReady_i = 1'b0;
    repeat (8) step();
    tests_run++;
    if (acc_log.size() !== 4) begin fails++; $display("FAIL bp_accept_count: got %0d want 4", acc_log.size()); end
    tests_run++;
    if (acc_log.size() < 4 || acc_log[3] !== 32'hC) begin fails++; $display("FAIL bp_last_addr: got n=%0d want acc[3]=0000000c", acc_log.size()); end
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0) begin fails++; $display("FAIL bp_full_reqvalid: got %b want 0", bus.ImemReqValid_o); end
    bus.InstrReady_i = 1'b1;
    repeat (8) step();
    tests_run++;
    if (dpc_log.size() < 5 || dpc_log[0] !== 32'h0 || dpc_log[1] !== 32'h4 || dpc_log[2] !== 32'h8 || dpc_log[3] !== 32'hC) begin
      fails++; $display("FAIL bp_drain_order: got n=%0d want 0,4,8,c first", dpc_log.size());
    end
    tests_run++;
    if (acc_log.size() < 5 || acc_log[4] !== 32'h10 || dpc_log.size() < 5 || dpc_log[4] !== 32'h10) begin
      fails++; $display("FAIL bp_resume: got acc=%0d dlv=%0d want 00000010 next", acc_log.size(), dpc_log.size());
    end
    $display("[TB] test_backpressure: %0d accepted, %0d delivered", acc_log.size(), dpc_log.size());
  endtask

  task automatic test_redirect();
    do_reset();
    rsp_hold = 1'b1;
    step(); step(); step(); // cycle 3: 0x0 and 0x4 in flight
    bus.ImemReqReady_i = 1'b0;
    bus.Redirect_i     = 1'b1;
    bus.RedirectPC_i   = 32'h100;
    #1;
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0) begin fails++; $display("FAIL redir_no_req: got %b want 0", bus.ImemReqValid_o); end
    step();
    bus.Redirect_i     = 1'b0;
    bus.ImemReqReady_i = 1'b1;
    rsp_hold           = 1'b0;
    #1;
    tests_run++;
    if (bus.InstrValid_o !== 1'b0) begin fails++; $display("FAIL redir_valid_next: got %b want 0", bus.InstrValid_o); end
    tests_run++;
    if (bus.ImemAddr_o !== 32'h100 || bus.ImemReqValid_o !== 1'b1) begin
      fails++; $display("FAIL redir_addr: got v=%b a=%h want v=1 a=00000100", bus.ImemReqValid_o, bus.ImemAddr_o);
    end
    repeat (10) step();
    tests_run++;
    if (dpc_log.size() < 2 || dpc_log[0] !== 32'h100 || din_log[0] !== 32'hC0DE_0100 || dpc_log[1] !== 32'h104) begin
      fails++; $display("FAIL redir_first_pc: got n=%0d want pc 00000100,00000104", dpc_log.size());
    end
    $display("[TB] test_redirect: %0d delivered after redirect", dpc_log.size());
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    repeat (4) step(); // cycle 4: PC 0x4 at the head
    tests_run++;
    if (bus.InstrValid_o !== 1'b1 || bus.PC_o !== 32'h4) begin
      fails++; $display("FAIL rh_head: got iv=%b pc=%h want iv=1 pc=00000004", bus.InstrValid_o, bus.PC_o);
    end
    bus.Redirect_i   = 1'b1;
    bus.RedirectPC_i = 32'h200;
    step();
    bus.Redirect_i = 1'b0;
    #1;
    tests_run++;
    if (bus.InstrValid_o !== 1'b0 || bus.ImemAddr_o !== 32'h200) begin
      fails++; $display("FAIL rh_next: got iv=%b a=%h want iv=0 a=00000200", bus.InstrValid_o, bus.ImemAddr_o);
    end
    repeat (6) step();
    tests_run++;
    if (dpc_log.size() < 4 || dpc_log[1] !== 32'h4 || dpc_log[2] !== 32'h200 || dpc_log[3] !== 32'h204) begin
      fails++; $display("FAIL rh_sequence: got n=%0d want 0,4,200,204", dpc_log.size());
    end
    $display("[TB] test_redirect_handshake: %0d delivered", dpc_log.size());
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.InstrReady_i = 1'b0;
    repeat (8) step();
    tests_run++;
    if (bus.InstrValid_o !== 1'b1 || bus.PC_o !== 32'h0) begin
      fails++; $display("FAIL rm_full_head: got iv=%b pc=%h want iv=1 pc=00000000", bus.InstrValid_o, bus.PC_o);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0 || bus.InstrValid_o !== 1'b0 || bus.Instr_o !== 32'h13 || bus.PC_o !== 32'h0 || bus.ImemAddr_o !== 32'h0) begin
      fails++; $display("FAIL rm_outputs: got rv=%b iv=%b in=%h pc=%h a=%h want 0 0 00000013 0 0", bus.ImemReqValid_o, bus.InstrValid_o, bus.Instr_o, bus.PC_o, bus.ImemAddr_o);
    end
    rst = 1'b0;
    bus.InstrReady_i = 1'b1;
    #1;
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b0) begin fails++; $display("FAIL rm_boot: got %b want 0", bus.ImemReqValid_o); end
    step();
    tests_run++;
    if (bus.ImemReqValid_o !== 1'b1 || bus.ImemAddr_o !== 32'h0) begin
      fails++; $display("FAIL rm_restart: got v=%b a=%h want v=1 a=00000000", bus.ImemReqValid_o, bus.ImemAddr_o);
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (4) step();
    bus.Redirect_i   = 1'b1;
    bus.RedirectPC_i = 32'hFFFF_FFFC;
    step();
    bus.Redirect_i = 1'b0;
    repeat (6) step();
    tests_run++;
    if (acc_log.size() < 5 || acc_log[3] !== 32'hFFFF_FFFC || acc_log[4] !== 32'h0) begin
      fails++; $display("FAIL wrap_addr: got n=%0d want fffffffc then 00000000", acc_log.size());
    end
    tests_run++;
    if (dpc_log.size() < 4 || dpc_log[2] !== 32'hFFFF_FFFC || din_log[2] !== 32'hC0DE_FFFC || dpc_log[3] !== 32'h0) begin
      fails++; $display("FAIL wrap_deliver: got n=%0d want fffffffc/c0defffc then 00000000", dpc_log.size());
    end
    $display("[TB] test_wrap: %0d accepted", acc_log.size());
  endtask

  task automatic test_align();
    do_reset();
    repeat (4) step();
    bus.Redirect_i   = 1'b1;
    bus.RedirectPC_i = 32'h102;
    step();
    bus.Redirect_i = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    tests_run++;
    if (bus.ImemAddr_o !== 32'h100 || bus.Misalign_o !== 1'b1) begin
      fails++; $display("FAIL align_redirect: got a=%h m=%b want a=00000100 m=1", bus.ImemAddr_o, bus.Misalign_o);
    end
`else
    tests_run++;
    if (bus.ImemAddr_o !== 32'h102 || bus.Misalign_o !== 1'b0) begin
      fails++; $display("FAIL align_redirect: got a=%h m=%b want a=00000102 m=0", bus.ImemAddr_o, bus.Misalign_o);
    end
`endif
    step();
    tests_run++;
    if (bus.Misalign_o !== 1'b0) begin fails++; $display("FAIL align_pulse_end: got %b want 0", bus.Misalign_o); end
    $display("[TB] test_align done");
  endtask

  initial begin
    bus.ImemReqReady_i = 1'b1;
    bus.InstrReady_i   = 1'b1;
    bus.Redirect_i     = 1'b0;
    bus.RedirectPC_i   = 32'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_handshake();
    test_reset_mid();
    test_wrap();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
